// File: rtl/mat_row_loader.sv
// mat_row_loader: turns one "load row" command (base, count, stride) into a
// sequence of single-word reads on the memory-controller request side. Each
// returned word is presented on a valid/ready stream, and the final beat is
// flagged with last_o. Only one read is outstanding at a time.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start_i           command strobe, accepted only while busy_o=0
//   base_addr_i       first word address (sampled on accepted start)
//   count_i           number of words to read (sampled on accepted start)
//   stride_i          address increment between words (sampled on accepted start)
//   busy_o            command in progress
//   done_o            one-cycle pulse on command completion
//   do_tran_o         one-cycle transaction request to the controller
//   w_en_o            controller write enable, tied low (read-only block)
//   addr_o            controller transaction address
//   w_data_o          controller write data, tied low
//   r_data_i          controller read data, valid while tran_done_i=1
//   tran_done_i       controller completion pulse
//   data_o            stream data
//   valid_o           stream valid
//   last_o            final beat marker, qualified by valid_o
//   ready_i           stream ready from the consumer
module mat_row_loader #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  count_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  do_tran_o,
    output logic                  w_en_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] w_data_o,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    input  logic                  tran_done_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  last_o,
    input  logic                  ready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_FIN
    } state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [ADDR_WIDTH-1:0] stride_q;

    // The block never writes memory.
    assign w_en_o   = 1'b0;
    assign w_data_o = '0;

    // Command sequencer; addr_o doubles as the running address register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            stride_q  <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            do_tran_o <= 1'b0;
            addr_o    <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
        end else begin
            // Pulse outputs default low so they can never be held.
            do_tran_o <= 1'b0;
            done_o    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (count_i != '0) begin
                            addr_o    <= base_addr_i;
                            remaining <= count_i;
                            stride_q  <= stride_i;
                            do_tran_o <= 1'b1;
                            state     <= S_ISSUE;
                        end else begin
                            done_o <= 1'b1;
                            state  <= S_FIN;
                        end
                    end
                end
                // do_tran_o is high during this state only.
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tran_done_i) begin
                        data_o  <= r_data_i;
                        last_o  <= (remaining == CNT_WIDTH'(1));
                        valid_o <= 1'b1;
                        state   <= S_OUT;
                    end
                end
                // Next read is issued only after the pending beat is taken.
                S_OUT: begin
                    if (ready_i) begin
                        valid_o   <= 1'b0;
                        remaining <= remaining - CNT_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1)) begin
                            done_o <= 1'b1;
                            state  <= S_FIN;
                        end else begin
                            addr_o    <= addr_o + stride_q;
                            do_tran_o <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_FIN: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_row_loader.sv
// Testbench for mat_row_loader: a memory responder, a ready generator and a
// scoreboard monitor run alongside table-driven, hand-written and random
// commands. Expected addresses/beats come from base + i*stride arithmetic.
module tb_mat_row_loader;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 16;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [CW-1:0] count_i;
    logic [AW-1:0] stride_i;
    logic          busy_o;
    logic          done_o;
    logic          do_tran_o;
    logic          w_en_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] w_data_o;
    logic [DW-1:0] r_data_i;
    logic          tran_done_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic          ready_i;

    mat_row_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .base_addr_i(base_addr_i),
        .count_i    (count_i),
        .stride_i   (stride_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .do_tran_o  (do_tran_o),
        .w_en_o     (w_en_o),
        .addr_o     (addr_o),
        .w_data_o   (w_data_o),
        .r_data_i   (r_data_i),
        .tran_done_i(tran_done_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .last_o     (last_o),
        .ready_i    (ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [CW-1:0] cnt;
        logic [AW-1:0] stride;
        int            lat;
        int            rmode;
        int            exp_beats;
        logic [AW-1:0] exp_last_addr;
    } vec_t;

    logic [AW-1:0] addr_q[$];
    beat_t         beat_q[$];

    int            n_pass;
    int            n_total;
    int            lat;
    int            rmode;
    bit            mem_en;
    int            tran_seen;
    int            beats_seen;
    logic [AW-1:0] last_tran_addr;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {8{a, a ^ 16'h5A5A}};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b required %0b at %0t", name, act, exp, $time);
    endtask

    task automatic check_addr(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %04h required %04h at %0t", name, act, exp, $time);
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got an event where the model required none at %0t", name, $time);
    endtask

    // Scoreboard: compares requests and beats against the queued model.
    task automatic monitor_loop();
        logic          prev_tran  = 1'b0;
        logic          prev_valid = 1'b0;
        logic          prev_ready = 1'b0;
        logic          prev_last  = 1'b0;
        logic          exp_done   = 1'b0;
        logic          nxt_done;
        logic [DW-1:0] prev_data  = '0;
        logic [AW-1:0] a;
        beat_t         b;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_tran  = 1'b0;
                prev_valid = 1'b0;
                prev_ready = 1'b0;
                exp_done   = 1'b0;
            end else begin
                nxt_done = 1'b0;
                if (do_tran_o) begin
                    check_bit("tran_back_to_back", prev_tran, 1'b0);
                    check_bit("tran_with_beat_pending", valid_o, 1'b0);
                    check_bit("w_en", w_en_o, 1'b0);
                    check_data("w_data", w_data_o, '0);
                    if (addr_q.size() == 0) fail_now("unexpected_tran");
                    else begin
                        a = addr_q.pop_front();
                        check_addr("tran_addr", addr_o, a);
                    end
                    tran_seen++;
                    last_tran_addr = addr_o;
                end
                if (valid_o && prev_valid && !prev_ready) begin
                    check_data("data_hold", data_o, prev_data);
                    check_bit("last_hold", last_o, prev_last);
                end
                if (valid_o && ready_i) begin
                    if (beat_q.size() == 0) fail_now("unexpected_beat");
                    else begin
                        b = beat_q.pop_front();
                        check_data("beat_data", data_o, b.data);
                        check_bit("beat_last", last_o, b.last);
                    end
                    beats_seen++;
                    nxt_done = last_o;
                end
                if (start_i && !busy_o && count_i == '0) nxt_done = 1'b1;
                if (done_o || exp_done) check_bit("done_pulse", done_o, exp_done);
                exp_done   = nxt_done;
                prev_tran  = do_tran_o;
                prev_valid = valid_o;
                prev_ready = ready_i;
                prev_last  = last_o;
                prev_data  = data_o;
            end
        end
    endtask

    // Memory model: acknowledges each request 'lat' cycles later.
    task automatic responder_loop();
        logic [AW-1:0] ra;
        forever begin
            @(negedge clk);
            if (do_tran_o && mem_en && !reset) begin
                ra = addr_o;
                repeat (lat) @(posedge clk);
                #1;
                tran_done_i = 1'b1;
                r_data_i    = mem_word(ra);
                @(posedge clk);
                #1;
                tran_done_i = 1'b0;
                r_data_i    = {8{$urandom()}};
            end
        end
    endtask

    // rmode 0: always ready, 1: random, 2: five stall cycles per beat.
    task automatic ready_loop();
        int stall = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: ready_i = 1'b1;
                1: ready_i = 1'($urandom_range(0, 1));
                default: begin
                    if (!valid_o) begin
                        stall   = 0;
                        ready_i = 1'b0;
                    end else begin
                        stall++;
                        ready_i = (stall > 5);
                    end
                end
            endcase
        end
    endtask

    task automatic start_cmd(input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                             input logic [AW-1:0] stride, input bit model);
        logic [AW-1:0] a;
        if (model) begin
            for (int i = 0; i < int'(cnt); i++) begin
                a = AW'(32'(base) + 32'(i) * 32'(stride));
                addr_q.push_back(a);
                beat_q.push_back('{mem_word(a), (i == int'(cnt) - 1)});
            end
        end
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = base;
        count_i     = cnt;
        stride_i    = stride;
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        base_addr_i = AW'($urandom());
        count_i     = CW'($urandom());
        stride_i    = AW'($urandom());
    endtask

    // Call at a negedge; returns at the negedge of the done_o cycle.
    task automatic wait_done(input int budget, output bit ok);
        int c = 0;
        ok = done_o;
        while (!ok && c < budget) begin
            @(negedge clk);
            ok = done_o;
            c++;
        end
        if (!ok) fail_now("done_timeout");
    endtask

    task automatic finish_cmd(input int budget);
        bit ok;
        wait_done(budget, ok);
        @(negedge clk);
        check_bit("busy_after_done", busy_o, 1'b0);
        check_int("model_addrs_left", addr_q.size(), 0);
        check_int("model_beats_left", beat_q.size(), 0);
        if (!ok) begin
            addr_q.delete();
            beat_q.delete();
        end
    endtask

    task automatic run_one(input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                           input logic [AW-1:0] stride, input int l, input int rm,
                           output int nt, output int nb, output logic [AW-1:0] la);
        int t0;
        int b0;
        lat   = l;
        rmode = rm;
        t0    = tran_seen;
        b0    = beats_seen;
        start_cmd(base, cnt, stride, 1'b1);
        @(negedge clk);
        check_bit("start_to_tran", do_tran_o, cnt != '0);
        check_bit("start_to_done", done_o, cnt == '0);
        finish_cmd(50 + int'(cnt) * 30);
        nt = tran_seen - t0;
        nb = beats_seen - b0;
        la = last_tran_addr;
    endtask

    vec_t          vecs[7];
    int            nt;
    int            nb;
    int            t0;
    logic [AW-1:0] la;
    logic [AW-1:0] rb;
    logic [CW-1:0] rc;
    bit            ok;

    initial begin
        reset          = 1'b1;
        start_i        = 1'b0;
        base_addr_i    = '0;
        count_i        = '0;
        stride_i       = '0;
        tran_done_i    = 1'b0;
        r_data_i       = '0;
        ready_i        = 1'b1;
        lat            = 2;
        rmode          = 0;
        mem_en         = 1'b1;
        n_pass         = 0;
        n_total        = 0;
        tran_seen      = 0;
        beats_seen     = 0;
        last_tran_addr = '0;

        vecs[0] = '{16'h0100, 8'd4,   16'h0001, 2, 0, 4,   16'h0103};
        vecs[1] = '{16'h0040, 8'd3,   16'h0003, 1, 2, 3,   16'h0046};
        vecs[2] = '{16'h0010, 8'd0,   16'h0005, 2, 0, 0,   16'h0000};
        vecs[3] = '{16'h0020, 8'd1,   16'h0007, 3, 0, 1,   16'h0020};
        vecs[4] = '{16'hFFFE, 8'd3,   16'h0002, 2, 1, 3,   16'h0002};
        vecs[5] = '{16'h1234, 8'd3,   16'h0000, 1, 1, 3,   16'h1234};
        vecs[6] = '{16'h0000, 8'd255, 16'h0001, 1, 0, 255, 16'h00FE};

        fork
            monitor_loop();
            responder_loop();
            ready_loop();
        join_none

        // Reset state
        @(posedge clk);
        #1;
        check_bit("rst_busy", busy_o, 1'b0);
        check_bit("rst_done", done_o, 1'b0);
        check_bit("rst_tran", do_tran_o, 1'b0);
        check_bit("rst_valid", valid_o, 1'b0);
        check_bit("rst_last", last_o, 1'b0);
        check_addr("rst_addr", addr_o, '0);
        check_data("rst_data", data_o, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed table
        foreach (vecs[k]) begin
            run_one(vecs[k].base, vecs[k].cnt, vecs[k].stride, vecs[k].lat, vecs[k].rmode, nt, nb, la);
            check_int($sformatf("vec%0d_trans", k), nt, vecs[k].exp_beats);
            check_int($sformatf("vec%0d_beats", k), nb, vecs[k].exp_beats);
            if (vecs[k].exp_beats > 0) check_addr($sformatf("vec%0d_last_addr", k), la, vecs[k].exp_last_addr);
        end

        // Second start while waiting on the controller is ignored
        lat   = 3;
        rmode = 0;
        t0    = tran_seen;
        start_cmd(16'h0400, 8'd3, 16'h0001, 1'b1);
        @(posedge clk);
        #1;
        check_bit("busy_in_wait", busy_o, 1'b1);
        start_i     = 1'b1;
        base_addr_i = 16'h0200;
        count_i     = 8'd5;
        stride_i    = 16'h0009;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        finish_cmd(200);
        check_int("busy_start_trans", tran_seen - t0, 3);
        check_addr("busy_start_last_addr", last_tran_addr, 16'h0402);
        run_one(16'h0500, 8'd2, 16'h0004, 1, 0, nt, nb, la);
        check_int("after_busy_beats", nb, 2);
        check_addr("after_busy_last_addr", la, 16'h0504);

        // Reset while waiting, then a stale completion
        mem_en = 1'b0;
        rmode  = 0;
        addr_q.push_back(16'h0300);
        start_cmd(16'h0300, 8'd3, 16'h0001, 1'b0);
        @(negedge clk);
        check_bit("mid_rst_tran", do_tran_o, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_bit("mid_rst_busy", busy_o, 1'b0);
        check_bit("mid_rst_tran_low", do_tran_o, 1'b0);
        check_bit("mid_rst_valid", valid_o, 1'b0);
        check_bit("mid_rst_last", last_o, 1'b0);
        check_bit("mid_rst_done", done_o, 1'b0);
        check_addr("mid_rst_addr", addr_o, '0);
        check_data("mid_rst_data", data_o, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        addr_q.delete();
        beat_q.delete();
        @(posedge clk);
        #1;
        tran_done_i = 1'b1;
        r_data_i    = mem_word(16'h0300);
        @(posedge clk);
        #1;
        tran_done_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_bit("stale_valid", valid_o, 1'b0);
            check_data("stale_data", data_o, '0);
            check_bit("stale_busy", busy_o, 1'b0);
        end
        mem_en = 1'b1;
        run_one(16'h0700, 8'd2, 16'h0010, 2, 1, nt, nb, la);
        check_int("post_rst_beats", nb, 2);
        check_addr("post_rst_last_addr", la, 16'h0710);

        // Random commands against the arithmetic model
        for (int r = 0; r < 40; r++) begin
            rb = AW'($urandom());
            rc = CW'($urandom_range(1, 12));
            run_one(rb, rc, AW'($urandom()), int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), nt, nb, la);
            check_int("rand_beats", nb, int'(rc));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
